cic_decim_multi: RTL

- Parametrised multi-channel CIC decimator for 1-bit (sigma-delta / comparator) samples in the AM receiver datapath.
- Sits after the 1-bit mixer (I/Q or more channels) and before the envelope/audio stage.
- Generalises the fixed single-path decimator: configurable order, decimation ratio, channel count and output width, plus a synchronous clear and an output valid strobe.

---
 rtl/cic_decim_multi.sv | 119 +++++++++++
 1 files changed

// File: rtl/cic_decim_multi.sv
// -----------------------------------------------------------------------------
// cic_decim_multi
//   Multi-channel CIC decimator for 1-bit (sigma-delta / comparator) samples.
//   Each channel runs ORDER registered integrators at the input rate, followed
//   by ORDER comb stages evaluated once per decimation frame (R = 2^DEC_LOG2
//   input samples). All channels share the sample counter, the decimation
//   strobe and the output valid.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   en         input sample strobe; a sample is consumed only when en=1
//   sync_clr   synchronous clear; same effect as rst at the next edge, wins over en
//   din        NUM_CH one-bit samples; 1 -> +1, 0 -> -1
//   dout       channel c in bits [c*OUT_W +: OUT_W], two's complement
//   out_valid  one-cycle pulse when dout is updated
//   phase      input-sample index within the current decimation frame
// -----------------------------------------------------------------------------
module cic_decim_multi #(
  parameter int NUM_CH   = 2,
  parameter int ORDER    = 3,
  parameter int DEC_LOG2 = 6,
  parameter int OUT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      sync_clr,
  input  logic [NUM_CH-1:0]         din,
  output logic [NUM_CH*OUT_W-1:0]   dout,
  output logic                      out_valid,
  output logic [DEC_LOG2-1:0]       phase
);

  localparam int W     = ORDER*DEC_LOG2 + 2;
  localparam int SHIFT = W - OUT_W;

  // Map a 1-bit sample to +1 / -1 at accumulator width.
  function automatic logic signed [W-1:0] map_sample(input logic b);
    logic signed [W-1:0] r;
    r = b ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
    return r;
  endfunction

  // Truncating output scaler: arithmetic shift, no rounding. The CIC gain
  // bound guarantees the result fits, so no saturation is needed.
  function automatic logic signed [OUT_W-1:0] trunc_out(input logic signed [W-1:0] v);
    return OUT_W'(v >>> SHIFT);
  endfunction

  logic signed [W-1:0] integ_p0 [NUM_CH][ORDER];
  logic signed [W-1:0] dly_p1   [NUM_CH][ORDER];
  logic signed [W-1:0] comb_y   [NUM_CH][ORDER+1];
  logic                vld_p1;

  // ---- stage p1: comb chain, evaluated combinationally during the strobe cycle
  always_comb begin
    comb_y = '{default: '0};
    for (int c = 0; c < NUM_CH; c++) begin
      comb_y[c][0] = integ_p0[c][ORDER-1];
      for (int k = 0; k < ORDER; k++) begin
        comb_y[c][k+1] = comb_y[c][k] - dly_p1[c][k];
      end
    end
  end

  // ---- stage p0 (integrators/counter), p1 (comb delays), p2 (output) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= '0;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < ORDER; k++) begin
          integ_p0[c][k] <= '0;
          dly_p1[c][k]   <= '0;
        end
      end
    end else if (sync_clr) begin
      // Discards any partial frame and cancels a pending strobe.
      phase     <= '0;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < ORDER; k++) begin
          integ_p0[c][k] <= '0;
          dly_p1[c][k]   <= '0;
        end
      end
    end else begin
      out_valid <= vld_p1;
      vld_p1    <= en && (phase == {DEC_LOG2{1'b1}});

      if (en) begin
        phase <= phase + DEC_LOG2'(1);
        // Registered cascade: each stage adds the pre-edge value of the one
        // before it. Wrap-around modulo 2^W is intentional.
        for (int c = 0; c < NUM_CH; c++) begin
          integ_p0[c][0] <= integ_p0[c][0] + map_sample(din[c]);
          for (int k = 1; k < ORDER; k++) begin
            integ_p0[c][k] <= integ_p0[c][k] + integ_p0[c][k-1];
          end
        end
      end

      if (vld_p1) begin
        for (int c = 0; c < NUM_CH; c++) begin
          for (int k = 0; k < ORDER; k++) begin
            dly_p1[c][k] <= comb_y[c][k];
          end
          dout[c*OUT_W +: OUT_W] <= trunc_out(comb_y[c][ORDER]);
        end
      end
    end
  end

endmodule
